// File: rtl/vlc_bit_packer.sv
// Packs variable-length DC/AC codes into an MSB-first stream of 32-bit words per slice.
// Optional bit_count output is enabled by defining VLC_PACKER_BIT_COUNT_EN.
module vlc_bit_packer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        slice_start,
    input  logic        vlc_valid,
    input  logic [31:0] vlc_code,
    input  logic [5:0]  vlc_length,
    input  logic        flush,
    output logic [31:0] out_word,
    output logic        out_valid,
    output logic        done,
    output logic [15:0] word_count,
    output logic        overrun_err
`ifdef VLC_PACKER_BIT_COUNT_EN
    ,
    output logic [31:0] bit_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [63:0] acc;
    logic [63:0] acc_next;
    logic [6:0]  fill;
    logic [6:0]  fill_next;

    logic [5:0]  code_len;
    logic [6:0]  code_len_ext;
    logic        code_present;
    logic [63:0] code_bits;
    logic [6:0]  place_shift;
    logic [63:0] appended;
    logic [6:0]  post_fill;

    logic        emit;
    logic [31:0] emit_word;
    logic        set_overrun;
    logic        done_next;
    logic        count_bits;

    // Lengths above 32 are clamped; bits above the length are masked off before placement.
    assign code_len     = (vlc_length > 6'd32) ? 6'd32 : vlc_length;
    assign code_len_ext = {1'b0, code_len};
    assign code_present = vlc_valid && (code_len != 6'd0);
    assign code_bits    = code_present ? ({32'd0, vlc_code} & ((64'd1 << code_len) - 64'd1)) : 64'd0;
    assign place_shift  = 7'd64 - fill - code_len_ext;
    assign appended     = acc | (code_bits << place_shift);
    assign post_fill    = code_present ? (fill + code_len_ext) : fill;

    always_comb begin
        state_next  = state;
        acc_next    = acc;
        fill_next   = fill;
        emit        = 1'b0;
        emit_word   = appended[63:32];
        set_overrun = 1'b0;
        done_next   = 1'b0;
        count_bits  = 1'b0;

        if (slice_start) begin
            state_next = PACK;
            acc_next   = 64'd0;
            fill_next  = 7'd0;
        end else begin
            case (state)
                IDLE: begin
                    set_overrun = code_present;
                end
                PACK: begin
                    count_bits = code_present;
                    if (flush) begin
                        if (post_fill > 7'd32) begin
                            emit       = 1'b1;
                            acc_next   = appended << 32;
                            fill_next  = post_fill - 7'd32;
                            state_next = FLUSH;
                        end else begin
                            // Partial word is already zero below the fill point, so it is its own padding.
                            emit       = (post_fill != 7'd0);
                            done_next  = (post_fill == 7'd0);
                            acc_next   = 64'd0;
                            fill_next  = 7'd0;
                            state_next = DONE;
                        end
                    end else if (post_fill >= 7'd32) begin
                        emit      = 1'b1;
                        acc_next  = appended << 32;
                        fill_next = post_fill - 7'd32;
                    end else begin
                        acc_next  = appended;
                        fill_next = post_fill;
                    end
                end
                FLUSH: begin
                    emit        = 1'b1;
                    emit_word   = acc[63:32];
                    acc_next    = 64'd0;
                    fill_next   = 7'd0;
                    set_overrun = code_present;
                    state_next  = DONE;
                end
                DONE: begin
                    // An empty flush already raised done on entry; avoid a second pulse.
                    done_next   = !done;
                    set_overrun = code_present;
                    state_next  = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            acc   <= 64'd0;
            fill  <= 7'd0;
        end else begin
            state <= state_next;
            acc   <= acc_next;
            fill  <= fill_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_word    <= 32'd0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
            word_count  <= 16'd0;
            overrun_err <= 1'b0;
        end else begin
            out_valid <= emit;
            done      <= done_next;
            if (emit) begin
                out_word <= emit_word;
            end
            if (slice_start) begin
                word_count  <= 16'd0;
                overrun_err <= 1'b0;
            end else begin
                if (emit && (word_count != 16'hFFFF)) begin
                    word_count <= word_count + 16'd1;
                end
                if (set_overrun) begin
                    overrun_err <= 1'b1;
                end
            end
        end
    end

`ifdef VLC_PACKER_BIT_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_count <= 32'd0;
        end else if (slice_start) begin
            bit_count <= 32'd0;
        end else if (count_bits) begin
            bit_count <= bit_count + {26'd0, code_len};
        end
    end
`endif

endmodule

// File: doc/vlc_bit_packer.md
# vlc_bit_packer

Packs the variable-length codes from the DC and AC VLC stages into a contiguous MSB-first stream of 32-bit words for one slice. It sits directly downstream of the DC/AC VLC encoders. It is framed by the sequencer's `slice_start` and AC `ac_vlc_output_flush` strobes, with its code strobe driven from the `dc_vlc_output_enable`/`ac_vlc_output_enable` windows. Output words go to the slice buffer; `done` and `word_count` close out the slice.

## Interface
- No parameters; all widths fixed.
- `clock`  in  1  system clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `slice_start`  in  1  one-cycle pulse; opens a slice, clears all slice state.
- `vlc_valid`  in  1  code strobe (DC or AC output enable, ORed upstream).
- `vlc_code`  in  32  code value; only `vlc_code[vlc_length-1:0]` significant, upper bits ignored.
- `vlc_length`  in  6  code length 0..32; 0 = no code; values >32 are treated as 32.
- `flush`  in  1  one-cycle pulse; last code of slice (may coincide with `vlc_valid`).
- `out_word`  out  32  packed word, first bit in bit 31.
- `out_valid`  out  1  one-cycle qualifier for `out_word`.
- `done`  out  1  one-cycle pulse after the final word of the slice.
- `word_count`  out  16  words emitted since `slice_start`; holds after `done`.
- `overrun_err`  out  1  sticky; code arrived outside PACK state; cleared by `slice_start`.
- `bit_count`  out  32  present only with `VLC_PACKER_BIT_COUNT_EN`.

## Operation
- Internal: 64-bit accumulator `acc` (MSB-aligned), 7-bit `fill` (0..63), 2-bit FSM.
- States: IDLE, PACK, FLUSH, DONE. Reset → IDLE.
- IDLE: `vlc_valid`/`flush` ignored; `vlc_valid` with length≠0 sets `overrun_err`. `slice_start` → PACK.
- PACK, `vlc_valid` with L≠0: append L code bits below existing `fill` bits; post-fill F = fill+L (≤63 because fill<32 before append).
  - F≥32: emit `acc[63:32]`, shift left 32, fill = F−32.
  - F<32: no emit, fill = F.
- PACK, `flush` (same-cycle code appended first, as above, giving F):
  - F>32: emit full word; remainder F−32 → FLUSH.
  - F=32: emit full word → DONE.
  - 0<F<32: emit `acc[63:32]` with unused LSBs zero → DONE.
  - F=0: no emit → DONE.
- FLUSH: emit remainder zero-padded; `vlc_valid` sets `overrun_err`, code dropped → DONE.
- DONE: `done`=1 for this cycle; → IDLE. Codes here set `overrun_err`, dropped.
- `slice_start` in any state: abort current slice, discard `acc`, fill=0, `word_count`=0, `overrun_err`=0, → PACK. It takes priority over `vlc_valid`/`flush` in the same cycle; those are ignored.
- `word_count` increments per `out_valid`; saturates at 0xFFFF.

## Timing
- Reset values: `out_word`=0, `out_valid`=0, `done`=0, `word_count`=0, `overrun_err`=0, `bit_count`=0, fill=0, state IDLE.
- Latency: `out_valid` rises the cycle after the input cycle that completes a word. All outputs are registered.
- Throughput: one code per cycle sustained in PACK. There is no backpressure; the downstream stage must accept every `out_valid`.
- Flush: the padded or last word appears cycle N+1 (N = flush cycle), or N+2 via FLUSH. `done` is on the cycle after the last `out_valid`, or N+1 when F=0.
- `out_word` holds its last value when `out_valid`=0.
- Asynchronous reset mid-slice: all state and outputs return to reset values immediately; partial data is lost.

## Configuration
- `VLC_PACKER_BIT_COUNT_EN` defined: `bit_count` port exists. It counts code bits appended since `slice_start` (padding excluded), is cleared by `slice_start`, and wraps at 2^32.
- Undefined: no `bit_count` port or counter logic; all other behaviour is identical.

## Test plan
- start; codes (0x5,L3),(0x0,L1),(0xABCD,L16) on consecutive cycles; flush with last code → one word 0xAABCD000, `done` next cycle, `word_count`=1.
- start; (0xFFFFFFFF,L32) twice → 0xFFFFFFFF on two consecutive cycles each one cycle after its input; flush alone → no word, `done`, `word_count`=2.
- start; (0xFFFFF,L20), then (0x0,L20)+flush → 0xFFFFF000, then 0x00000000 via FLUSH, `done`, `word_count`=2; with macro `bit_count`=40.
- L=0 codes and code bits above L (e.g. 0xFFFFFFFF,L4 → only 0xF) are ignored; vlc_valid while IDLE → `overrun_err`=1 until next `slice_start`.
- `slice_start` mid-slice with fill=17 → no word emitted for old data; new slice packs from bit 31; assert `reset_n` low mid-slice → all outputs 0 immediately.
- Run with and without `VLC_PACKER_BIT_COUNT_EN`; identical `out_word`/`done` streams.
